// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch and data stages.
// Data has priority; a fetch gets through after MAX_D_BURST back-to-back data grants.
module mem_port_arbiter #(
  parameter int MEM_LAT     = 2,
  parameter int MAX_D_BURST = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_adr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT  = 4'(MEM_LAT);
  localparam logic [3:0] MAXB = 4'(MAX_D_BURST);

  state_t        state, state_nxt;
  logic [3:0]    lat_cnt, lat_nxt;
  logic [3:0]    burst_cnt, burst_nxt;
  logic          owner_d, owner_nxt;
  logic          op_we, op_we_nxt;
  logic          complete, if_elig, d_elig, can_issue, issue_if, issue_d;
  logic          mem_en_nxt, mem_we_nxt, if_valid_nxt, d_valid_nxt;
  logic [AW-1:0] mem_adr_nxt;
  logic [DW-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      burst_cnt <= '0;
      owner_d   <= 1'b0;
      op_we     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_nxt;
      burst_cnt <= burst_nxt;
      owner_d   <= owner_nxt;
      op_we     <= op_we_nxt;
      mem_en    <= mem_en_nxt;
      mem_we    <= mem_we_nxt;
      mem_adr   <= mem_adr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_valid  <= if_valid_nxt;
      d_valid   <= d_valid_nxt;
    end
  end

  // The completing port still holds req at its completion edge, so it sits this edge out.
  always_comb begin
    complete  = (state == BUSY) && (lat_cnt == LAT);
    if_elig   = if_req && !(complete && !owner_d);
    d_elig    = d_req && !(complete && owner_d);
    can_issue = (state == IDLE) || complete;
    issue_if  = can_issue && if_elig && (!d_elig || (burst_cnt == MAXB));
    issue_d   = can_issue && d_elig && !issue_if;

    state_nxt = state;
    lat_nxt   = lat_cnt;
    owner_nxt = owner_d;
    op_we_nxt = op_we;
    if (issue_if || issue_d) begin
      state_nxt = BUSY;
      lat_nxt   = 4'd1;
      owner_nxt = issue_d;
      op_we_nxt = issue_d && d_we;
    end else if (complete) begin
      state_nxt = IDLE;
      lat_nxt   = '0;
    end else if (state == BUSY) begin
      lat_nxt   = lat_cnt + 4'd1;
    end

    burst_nxt = burst_cnt;
    if (!if_req || issue_if)
      burst_nxt = '0;
    else if (issue_d && (burst_cnt != MAXB))
      burst_nxt = burst_cnt + 4'd1;
  end

  always_comb begin
    mem_en_nxt    = issue_if || issue_d;
    mem_we_nxt    = issue_d && d_we;
    mem_adr_nxt   = mem_adr;
    mem_wdata_nxt = mem_wdata;
    if (issue_d) begin
      mem_adr_nxt   = d_adr;
      mem_wdata_nxt = d_wdata;
    end else if (issue_if) begin
      mem_adr_nxt   = if_adr;
    end

    if_valid_nxt = complete && !owner_d;
    d_valid_nxt  = complete && owner_d;
    if_rdata_nxt = if_valid_nxt ? mem_rdata : if_rdata;
    d_rdata_nxt  = (d_valid_nxt && !op_we) ? mem_rdata : d_rdata;

    stall_if  = if_req && !if_valid;
    stall_mem = d_req && !d_valid;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiters (MEM_LAT=2/MAX_D_BURST=3 and MEM_LAT=1/MAX_D_BURST=1) share stimulus;
// only the active one is out of reset. A timestamp-based model predicts every cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic [1:0]  rst = 2'b11;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_adr = '0, d_adr = '0, d_wdata = '0;
  logic [31:0] mem_rdata [2];
  logic [31:0] if_rdata_o [2], d_rdata_o [2], mem_adr_o [2], mem_wdata_o [2];
  logic        if_valid_o [2], d_valid_o [2], mem_en_o [2], mem_we_o [2];
  logic        stall_if_o [2], stall_mem_o [2];

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2), .MAX_D_BURST(3), .AW(32), .DW(32)) dut0 (
    .clk(clk), .reset(rst[0]),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata_o[0]), .if_valid(if_valid_o[0]),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_o[0]), .d_valid(d_valid_o[0]),
    .mem_en(mem_en_o[0]), .mem_we(mem_we_o[0]), .mem_adr(mem_adr_o[0]),
    .mem_wdata(mem_wdata_o[0]), .mem_rdata(mem_rdata[0]),
    .stall_if(stall_if_o[0]), .stall_mem(stall_mem_o[0]));

  mem_port_arbiter #(.MEM_LAT(1), .MAX_D_BURST(1), .AW(32), .DW(32)) dut1 (
    .clk(clk), .reset(rst[1]),
    .if_req(if_req), .if_adr(if_adr), .if_rdata(if_rdata_o[1]), .if_valid(if_valid_o[1]),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
    .d_rdata(d_rdata_o[1]), .d_valid(d_valid_o[1]),
    .mem_en(mem_en_o[1]), .mem_we(mem_we_o[1]), .mem_adr(mem_adr_o[1]),
    .mem_wdata(mem_wdata_o[1]), .mem_rdata(mem_rdata[1]),
    .stall_if(stall_if_o[1]), .stall_mem(stall_mem_o[1]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int maxb_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic logic [31:0] init_val(input int idx);
    return (32'(idx) * 32'h0101_0103) ^ 32'h5A00_0000;
  endfunction

  // Environment memory (reacts to DUT pins) and the model's own copy.
  logic [31:0] env_mem [2][1024];
  logic [31:0] mdl_mem [2][1024];
  logic [31:0] pipe    [2][16];

  // Reference model: each access is a transaction with a completion timestamp.
  int          t_m [2], done_m [2], burst_m [2];
  bit          busy_m [2], own_d_m [2], own_we_m [2], seen_m [2];
  logic [31:0] data_m [2];
  logic        e_en [2], e_we [2], e_iv [2], e_dv [2];
  logic [31:0] e_adr [2], e_wdata [2], e_ird [2], e_drd [2];

  task automatic model_step(input int i);
    bit comp, if_ok, d_ok;
    int g;
    t_m[i]++;
    if (rst[i]) begin
      seen_m[i] = 1; busy_m[i] = 0; burst_m[i] = 0;
      e_en[i] = 0; e_we[i] = 0; e_iv[i] = 0; e_dv[i] = 0;
      e_adr[i] = '0; e_wdata[i] = '0; e_ird[i] = '0; e_drd[i] = '0;
      return;
    end
    e_en[i] = 0; e_we[i] = 0; e_iv[i] = 0; e_dv[i] = 0;
    comp = busy_m[i] && (t_m[i] == done_m[i]);
    if (comp) begin
      busy_m[i] = 0;
      if (own_d_m[i]) begin
        e_dv[i] = 1;
        if (!own_we_m[i]) e_drd[i] = data_m[i];
      end else begin
        e_iv[i] = 1;
        e_ird[i] = data_m[i];
      end
    end
    if_ok = if_req && !(comp && !own_d_m[i]);
    d_ok  = d_req && !(comp && own_d_m[i]);
    g = 0;
    if (!busy_m[i]) begin
      if (if_ok && (!d_ok || burst_m[i] == maxb_of(i))) g = 1;
      else if (d_ok) g = 2;
    end
    if (!if_req || g == 1) burst_m[i] = 0;
    else if (g == 2 && burst_m[i] < maxb_of(i)) burst_m[i]++;
    if (g != 0) begin
      busy_m[i] = 1; done_m[i] = t_m[i] + lat_of(i); e_en[i] = 1;
      own_d_m[i] = (g == 2); own_we_m[i] = (g == 2) && d_we;
      e_we[i] = own_we_m[i];
      e_adr[i] = (g == 2) ? d_adr : if_adr;
      if (g == 2) e_wdata[i] = d_wdata;
      if (own_we_m[i]) mdl_mem[i][e_adr[i][11:2]] = d_wdata;
      else data_m[i] = mdl_mem[i][e_adr[i][11:2]];
    end
  endtask

  task automatic compare(input int i);
    check($sformatf("i%0d_mem_en", i), 32'(mem_en_o[i]), 32'(e_en[i]));
    check($sformatf("i%0d_mem_we", i), 32'(mem_we_o[i]), 32'(e_we[i]));
    check($sformatf("i%0d_if_valid", i), 32'(if_valid_o[i]), 32'(e_iv[i]));
    check($sformatf("i%0d_d_valid", i), 32'(d_valid_o[i]), 32'(e_dv[i]));
    check($sformatf("i%0d_if_rdata", i), if_rdata_o[i], e_ird[i]);
    check($sformatf("i%0d_d_rdata", i), d_rdata_o[i], e_drd[i]);
    check($sformatf("i%0d_stall_if", i), 32'(stall_if_o[i]), 32'(if_req && !e_iv[i]));
    check($sformatf("i%0d_stall_mem", i), 32'(stall_mem_o[i]), 32'(d_req && !e_dv[i]));
    if (e_en[i] || rst[i]) check($sformatf("i%0d_mem_adr", i), mem_adr_o[i], e_adr[i]);
    if ((e_en[i] && e_we[i]) || rst[i])
      check($sformatf("i%0d_mem_wdata", i), mem_wdata_o[i], e_wdata[i]);
  endtask

  // Memory returns read data exactly MEM_LAT edges after the issue edge; garbage otherwise.
  task automatic mem_env(input int i);
    for (int j = 15; j > 0; j--) pipe[i][j] = pipe[i][j-1];
    if (mem_en_o[i] === 1'b1 && mem_we_o[i] === 1'b1)
      env_mem[i][mem_adr_o[i][11:2]] = mem_wdata_o[i];
    if (mem_en_o[i] === 1'b1 && mem_we_o[i] === 1'b0)
      pipe[i][0] = env_mem[i][mem_adr_o[i][11:2]];
    else
      pipe[i][0] = $urandom;
    mem_rdata[i] = pipe[i][lat_of(i)-1];
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      model_step(i);
      if (seen_m[i]) compare(i);
      mem_env(i);
    end
  end

  // Requester side: mode 0 holds until valid, 1 random, 2 re-raise fetch+store, 3 fetch+load.
  int          act = 0, cyc = 0, if_seen = -1, d_seen = -1, n_en = 0;
  logic [31:0] if_val_dat, d_val_dat, en_wdata;
  logic        if_stall_v, en_we, last_iv, last_dv;

  task automatic step(input int mode);
    logic [9:0] w;
    @(negedge clk); #1;
    cyc++;
    last_iv = if_valid_o[act];
    last_dv = d_valid_o[act];
    if (mem_en_o[act]) begin
      n_en++; en_we = mem_we_o[act]; en_wdata = mem_wdata_o[act];
    end
    if (if_valid_o[act]) begin
      if_seen = cyc; if_val_dat = if_rdata_o[act]; if_stall_v = stall_if_o[act]; if_req = 0;
    end
    if (d_valid_o[act]) begin
      d_seen = cyc; d_val_dat = d_rdata_o[act]; d_req = 0;
    end
    if (mode >= 1) begin
      if (!if_req && (mode != 1 || $urandom_range(0, 2) != 0)) begin
        w = 10'($urandom_range(0, 1023));
        if_req = 1; if_adr = {20'h0, w, 2'b00};
      end
      if (!d_req && (mode != 1 || $urandom_range(0, 2) != 0)) begin
        w = 10'($urandom_range(0, 1023));
        d_req = 1; d_adr = {20'h0, w, 2'b00}; d_wdata = $urandom;
        d_we = (mode == 2) ? 1'b1 : (mode == 3) ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic restart();
    cyc = 0; if_seen = -1; d_seen = -1; n_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 1024; j++) begin
        env_mem[i][j] = init_val(j);
        mdl_mem[i][j] = init_val(j);
      end
    env_mem[0][16] = 32'h8C01_0004;
    mdl_mem[0][16] = 32'h8C01_0004;

    repeat (3) step(0);
    rst[0] = 1'b0;
    step(0);

    // Single fetch from 0x40.
    restart();
    if_req = 1; if_adr = 32'h40;
    step(0);
    check("tp1_mem_adr", mem_adr_o[0], 32'h40);
    repeat (3) step(0);
    check("tp1_latency", 32'(if_seen), 32'd3);
    check("tp1_if_rdata", if_val_dat, 32'h8C01_0004);
    check("tp1_stall_if", 32'(if_stall_v), 32'd0);

    // Simultaneous fetch and load: data first, fetch at the data completion edge.
    restart();
    if_req = 1; if_adr = 32'h80; d_req = 1; d_we = 0; d_adr = 32'h100;
    repeat (6) step(0);
    check("tp2_d_lat", 32'(d_seen), 32'd3);
    check("tp2_if_lat", 32'(if_seen), 32'd5);
    check("tp2_mem_en_cnt", 32'(n_en), 32'd2);
    check("tp2_d_rdata", d_val_dat, init_val(64));

    // Store leaves d_rdata at the previous load value.
    restart();
    d_req = 1; d_we = 1; d_adr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    repeat (4) step(0);
    check("tp3_d_lat", 32'(d_seen), 32'd3);
    check("tp3_mem_we", 32'(en_we), 32'd1);
    check("tp3_mem_wdata", en_wdata, 32'hDEAD_BEEF);
    check("tp3_d_rdata", d_val_dat, init_val(64));

    // Data stores and fetches both requesting continuously.
    restart();
    repeat (14) step(2);
    repeat (8) step(0);
    check("tp4_drained", 32'(if_req || d_req), 32'd0);

    // Reset one cycle after a data issue abandons the access.
    restart();
    d_req = 1; d_we = 0; d_adr = 32'h300;
    step(0);
    check("tp5_issue", 32'(mem_en_o[0]), 32'd1);
    rst[0] = 1'b1; d_req = 0;
    step(0);
    check("tp5_rst_en", 32'(mem_en_o[0]), 32'd0);
    check("tp5_rst_drd", d_rdata_o[0], 32'd0);
    rst[0] = 1'b0;
    repeat (3) step(0);
    check("tp5_no_dvalid", 32'(d_seen), 32'hFFFF_FFFF);
    restart();
    if_req = 1; if_adr = 32'h40;
    repeat (4) step(0);
    check("tp5_if_lat", 32'(if_seen), 32'd3);

    repeat (1500) step(1);
    repeat (8) step(0);

    // Switch to the MEM_LAT=1 instance.
    rst[0] = 1'b1; if_req = 0; d_req = 0;
    act = 1; rst[1] = 1'b0;
    repeat (2) step(0);
    restart();
    if_req = 1; if_adr = 32'h44; d_req = 1; d_we = 0; d_adr = 32'h104;
    for (int k = 1; k <= 10; k++) begin
      step(3);
      if (k >= 2) check("tp6_alternate", 32'(last_iv ^ last_dv), 32'd1);
    end
    repeat (4) step(0);
    repeat (1500) step(1);
    repeat (6) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
